serial_adder_ctrl: RTL

Sequencer that performs a WIDTH-bit addition bit-serially through a single 1-bit full-add cell, built from two half-adder stages plus an OR. Operands are latched on a start handshake and shifted LSB-first, one bit per clock, while a carry flip-flop carries between bits. The result is presented with a one-cycle done pulse. This is the area-minimal alternative to the parallel ripple adder in the adder examples.

---
 rtl/serial_adder_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one full-add cell (two half adders + OR)
// processes operands LSB-first, one bit per clock, with a carry flip-flop between bits.
// Ports: clk/rst (sync, active-high), start/a/b/cin request, busy/done status,
//        sum/cout registered result held until the next completion.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Single full-add cell built from two half-adder stages.
  logic s1, c1, s_bit, c2;
  assign s1    = a_q[0] ^ b_q[0];
  assign c1    = a_q[0] & b_q[0];
  assign s_bit = s1 ^ carry_q;
  assign c2    = s1 & carry_q;

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        carry_d = c1 | c2;
        acc_d   = {s_bit, acc_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        // The counter parks on the last index instead of incrementing, so it
        // never wraps even when WIDTH is a power of two.
        if (cnt_q == LAST) begin
          sum_d  = acc_d;
          cout_d = carry_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the next state and registered, so they are
  // clean flop outputs aligned with the state register.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
